data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
Data-memory slave that answers the processor's memory-stage requests.
- Inputs: read/write strobes, 16-bit word address, 16-bit write data.
- Output: 16-bit read data with a valid pulse.
- Backing store is a word-addressed synchronous RAM.
- After every reset, a clear sequencer zero-fills the RAM, and `busy` holds off the core until the fill completes.

Parameters:
- ADDR_W, 11: word-address bits actually decoded; DEPTH = 2^ADDR_W words.
- DATA_W, 16: word width; must equal the processor data path.
- INIT_VALUE, 16'h0000: value written to every word by the clear sequencer.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-low reset.
- MR  in  1: memory read request (processor MR after D/E buffer).
- MW  in  1: memory write request (processor MW after D/E buffer).
- dataMemAddr  in  16: word address.
- writeMemData  in  16: write data.
- memData  out  16: read data to write-back.
- memDataValid  out  1: one-cycle pulse; memData carries a fresh read result.
- busy  out  1: high while clearing; requests are ignored.
- addrError  out  1: one-cycle pulse for an out-of-range access.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low. It is sampled only at the clk rising edge; reset==0 at an edge resets the block.
- Reset values: state=CLEAR, clrAddr=0, memData=0, memDataValid=0, busy=1, addrError=0. RAM contents are not reset directly; the CLEAR pass overwrites them.
- Reset asserted mid-CLEAR or mid-READY: CLEAR restarts from clrAddr=0.
- Any pending read response is discarded: memDataValid is 0 in the cycle after the reset edge.
- States: CLEAR, READY.
- CLEAR, each cycle:
  - Writes INIT_VALUE to mem[clrAddr], then clrAddr increments.
  - On the write at clrAddr==DEPTH-1, the next state is READY and busy drops to 0 at that same edge.
  - Total: exactly DEPTH clear cycles after the first edge with reset==1.
- CLEAR ignores requests:
  - MR/MW are ignored: no RAM write, no memDataValid, no addrError.
  - memData holds 0.
- READY: the in-range test is dataMemAddr[15:ADDR_W]==0; the RAM index is dataMemAddr[ADDR_W-1:0].
- MW=1, in range: mem[index] <= writeMemData at the edge.
- MR=1, in range:
  - Read latency is 1 cycle: at the edge, memData <= mem[index] and memDataValid <= 1 for exactly one cycle.
  - Back-to-back reads give one valid pulse per request.
- MR=1 and MW=1 in the same cycle, same address: read-before-write. memData returns the old word and the RAM takes the new word. No error is flagged.
- Write then read of the same address in consecutive cycles: the read returns the newly written data (RAM is synchronous, no bypass needed).
- Out-of-range access (MR or MW):
  - No RAM access.
  - addrError pulses 1 the next cycle.
  - For MR, memData <= 0 and memDataValid still pulses 1, so the processor never stalls.
- No request: memDataValid=0, addrError=0, memData holds its last value.
- Response gating: responses are never generated for requests that arrive while busy=1.
- Stack-pointer pushes and pops, and the two-cycle CALL sequence that pushes PC low then PC high, are plain MW cycles; no special handling.

Test Plan:
1. Reset clear: hold reset=0 for 2 cycles, then release with ADDR_W=4 (DEPTH=16).
   - busy stays 1 for exactly 16 cycles, then 0.
   - Reads of addresses 0..15 then all return 16'h0000, each with a one-cycle memDataValid.
2. Write/read: in READY, write 16'hBEEF to addr 3, then read addr 3 the next cycle.
   - memData=16'hBEEF with memDataValid=1 one cycle after the read request.
   - memDataValid=0 the cycle after that.
3. Simultaneous access: addr 5 holds 16'h1111; drive MR=MW=1, addr 5, data 16'h2222.
   - Response is memData=16'h1111.
   - A following read of addr 5 returns 16'h2222.
4. Out of range: with ADDR_W=4, MW to 16'h0010 with data 16'hAAAA, then MR to 16'h0010.
   - addrError pulses once for each request.
   - The MR returns memData=0 with memDataValid=1.
   - addr 0 is still 0, i.e. the write did not alias into the RAM.
5. Requests during clear: drive MR=MW=1 to addr 2 with 16'h5555 while busy=1.
   - No memDataValid and no addrError.
   - After clear completes, addr 2 reads 16'h0000.
6. Reset mid-operation:
   - Assert reset during a read cycle: memDataValid=0 in the cycle after the reset edge.
   - Addr 3, previously written with 16'hBEEF, reads 0 after the new clear.
   - busy=1 for the full DEPTH cycles again.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Memory-stage request/response bundle between the processor (master) and the data memory (slave).
interface data_memory_responder_if #(
  parameter int unsigned DATA_W = 16
);
  logic              MR;
  logic              MW;
  logic [15:0]       dataMemAddr;
  logic [DATA_W-1:0] writeMemData;
  logic [DATA_W-1:0] memData;
  logic              memDataValid;
  logic              busy;
  logic              addrError;

  modport master (
    output MR, MW, dataMemAddr, writeMemData,
    input  memData, memDataValid, busy, addrError
  );

  modport slave (
    input  MR, MW, dataMemAddr, writeMemData,
    output memData, memDataValid, busy, addrError
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory for the processor memory stage; the RAM is zero-filled
// by a clear pass after every reset, and requests are ignored while that pass runs.
module data_memory_responder #(
  parameter int unsigned       ADDR_W     = 11,
  parameter int unsigned       DATA_W     = 16,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic                   clk,
  input logic                   reset,
  data_memory_responder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic [ADDR_W-1:0]   index;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                rd_hit;
  logic                rd_miss;
  logic                err_next;
  logic [DATA_W-1:0]   mem_data_q;
  logic                valid_q;
  logic                addr_error_q;

  assign in_range = ((bus.dataMemAddr >> ADDR_W) == '0);
  assign index    = bus.dataMemAddr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    bus.busy  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = index;
    ram_wdata = bus.writeMemData;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    err_next  = 1'b0;
    case (state)
      CLEAR: begin
        bus.busy  = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = INIT_VALUE;
      end
      READY: begin
        ram_we   = bus.MW & in_range;
        rd_hit   = bus.MR & in_range;
        rd_miss  = bus.MR & ~in_range;
        err_next = (bus.MR | bus.MW) & ~in_range;
      end
      default: bus.busy = 1'b1;
    endcase
  end

  // No reset on the array: the CLEAR pass is what initialises it.
  always_ff @(posedge clk) begin
    if (reset && ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_addr     <= '0;
      mem_data_q   <= '0;
      valid_q      <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      // The array read sees the pre-edge word, so MR+MW to one address is read-before-write.
      if (rd_hit)       mem_data_q <= mem[index];
      else if (rd_miss) mem_data_q <= '0;
      valid_q      <= rd_hit | rd_miss;
      addr_error_q <= err_next;
    end
  end

  assign bus.memData      = mem_data_q;
  assign bus.memDataValid = valid_q;
  assign bus.addrError    = addr_error_q;
endmodule
